route_compute_unit: RTL and testbench
=====================================

Name: route_compute_unit

Overview:
- Stage directly downstream of the router input queue.
- Pops flits from the show-ahead input queue and computes the output port of each head flit with minimal dimension-order routing (X, then Y, then Z) on a 3D torus.
- Locks that port for the remaining flits of the packet (wormhole) and presents flit plus port to the switch allocator through a one-entry registered valid/ready stage.

Parameters:
- X, 3'd0, this router's X coordinate
- Y, 3'd0, this router's Y coordinate
- Z, 3'd0, this router's Z coordinate
- DIM_X, 4, torus size in X (2..8)
- DIM_Y, 4, torus size in Y (2..8)
- DIM_Z, 4, torus size in Z (2..8)
- FLIT_SIZE, 64, flit width in bits

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- in_data  input  FLIT_SIZE  head of input queue; valid whenever in_empty=0
- in_empty  input  1  input queue empty
- in_dequeue  output  1  pop input queue this cycle
- out_data  output  FLIT_SIZE  registered flit
- out_valid  output  1  out_data/out_port valid
- out_ready  input  1  allocator accepts this cycle
- out_port  output  3  0 local, 1 X+, 2 X-, 3 Y+, 4 Y-, 5 Z+, 6 Z-
- out_tail  output  1  flit ends packet (tail or single)
- err_count  output  8  saturating protocol-error count

Behaviour:
- Flit fields:
  - type = in_data[FLIT_SIZE-1:FLIT_SIZE-2]: 00 body, 01 head, 10 tail, 11 single.
  - dest X = [FLIT_SIZE-3 -: 3], dest Y = [FLIT_SIZE-6 -: 3], dest Z = [FLIT_SIZE-9 -: 3].
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, out_port=0, out_tail=0, err_count=0, state=IDLE, locked port=0.
- in_dequeue = !in_empty && (!out_valid || out_ready). Combinational; no dequeue while rst=0.
- Latency: a flit dequeued in cycle N appears on out_* in cycle N+1.
- Output stage: out_valid stays high and out_* stay stable until out_ready=1. Accept and refill can occur in the same cycle, so a continuous stream runs at 1 flit/cycle.
- Route function (head and single flits):
  - dx = (destX - X) mod DIM_X, computed in 4-bit arithmetic by adding DIM_X when negative.
  - dx != 0: X+ if dx <= DIM_X/2 (tie goes positive), else X-.
  - dx = 0: same rule on Y, then on Z.
  - All offsets 0: local.
- FSM, updated on each dequeue:
  - IDLE, head: route it, store locked port, go to BUSY.
  - IDLE, single: route it, stay IDLE.
  - IDLE, body or tail: dequeue and drop (out_valid not set by this flit), err_count+1, stay IDLE.
  - BUSY, body: forward on locked port, stay BUSY.
  - BUSY, tail: forward on locked port with out_tail=1, go to IDLE.
  - BUSY, head or single: treat as a new packet (route, relock, next state per type as in IDLE), err_count+1.
- err_count saturates at 255.
- out_tail=1 for tail and single flits.
- State and lock change only on dequeue. Backpressure freezes everything.
- Reset asserted mid-packet: the lock is discarded, and the next flit must be a head.

Test Plan:
- Reset: hold rst=0 with in_empty=0 -> in_dequeue=0, out_valid=0, err_count=0. Release rst -> first dequeue on the next clock.
- Single-flit routing at X=1,Y=2,Z=0, DIM=4:
  - dest (1,2,0) -> port 0.
  - dest (3,2,0) -> port 1 (dx=2, tie).
  - dest (0,2,0) -> port 2 (dx=3).
  - dest (1,3,0) -> port 3.
  - dest (1,2,3) -> port 6.
  - Each flit: out_valid one cycle after dequeue, out_tail=1.
- Wormhole: head to (2,0,0) then 3 bodies then tail, back-to-back with out_ready=1 -> 5 consecutive out_valid cycles, all port 1, out_tail only on the last; FSM ends in IDLE.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> in_dequeue=0, out_data/out_port stable. Raise out_ready -> flow resumes at 1 flit/cycle with no loss or duplication.
- Protocol errors: body flit in IDLE -> dropped, err_count=1. Head while BUSY -> relock to the new route, err_count=2. 300 further stray bodies -> err_count=255.
- Async reset mid-packet: rst low for 1 cycle after a head -> outputs cleared immediately. A following body flit counts as an error.

Source files
------------

// File: rtl/route_compute_unit_if.sv
// Purpose: bundles the input-queue pop interface, the allocator valid/ready
//          stage and the error counter of route_compute_unit.
// Signals:
//   in_data/in_empty   head of show-ahead input queue, queue empty flag
//   in_dequeue         pop strobe back to the queue
//   out_data/out_valid registered flit and its valid flag
//   out_ready          allocator accept
//   out_port/out_tail  output port (0 local..6 Z-) and end-of-packet flag
//   err_count          saturating protocol-error count
// Modports: master = routing unit side, slave = queue/allocator side.
interface route_compute_unit_if #(
    parameter int unsigned FLIT_SIZE = 64
);
    logic [FLIT_SIZE-1:0] in_data;
    logic                 in_empty;
    logic                 in_dequeue;
    logic [FLIT_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_port;
    logic                 out_tail;
    logic [7:0]           err_count;

    modport master (
        input  in_data, in_empty, out_ready,
        output in_dequeue, out_data, out_valid, out_port, out_tail, err_count
    );

    modport slave (
        output in_data, in_empty, out_ready,
        input  in_dequeue, out_data, out_valid, out_port, out_tail, err_count
    );
endinterface

// File: rtl/route_compute_unit.sv
// Purpose: route compute stage of a 3D-torus router. Pops flits from the
//          show-ahead input queue, computes minimal dimension-order (X,Y,Z)
//          routes for head/single flits, locks the port for the rest of the
//          packet and presents flit + port through a one-entry registered
//          valid/ready stage.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset
//   bus   route_compute_unit_if.master (queue side, allocator side, err_count)
module route_compute_unit #(
    parameter logic [2:0]  X         = 3'd0,
    parameter logic [2:0]  Y         = 3'd0,
    parameter logic [2:0]  Z         = 3'd0,
    parameter int unsigned DIM_X     = 4,
    parameter int unsigned DIM_Y     = 4,
    parameter int unsigned DIM_Z     = 4,
    parameter int unsigned FLIT_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    route_compute_unit_if.master bus
);

    localparam int unsigned PORT_W = 3;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] P_XP    = 3'd1;
    localparam logic [PORT_W-1:0] P_XM    = 3'd2;
    localparam logic [PORT_W-1:0] P_YP    = 3'd3;
    localparam logic [PORT_W-1:0] P_YM    = 3'd4;
    localparam logic [PORT_W-1:0] P_ZP    = 3'd5;
    localparam logic [PORT_W-1:0] P_ZM    = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state;
    logic [PORT_W-1:0]     r_lock_port;
    logic                  r_out_valid;
    logic [FLIT_SIZE-1:0]  r_out_data;
    logic [PORT_W-1:0]     r_out_port;
    logic                  r_out_tail;
    logic [7:0]            r_err_count;

    state_t                w_state_nxt;
    logic [PORT_W-1:0]     w_lock_nxt;
    logic                  w_err_inc;
    logic                  w_fwd;
    logic [PORT_W-1:0]     w_port_nxt;
    logic                  w_tail_nxt;
    logic                  w_deq;
    logic [1:0]            w_type;
    logic [2:0]            w_dst_x;
    logic [2:0]            w_dst_y;
    logic [2:0]            w_dst_z;
    logic [3:0]            w_dx;
    logic [3:0]            w_dy;
    logic [3:0]            w_dz;
    logic [PORT_W-1:0]     w_route;

    // Torus offset (dst - own) mod dim in 4-bit arithmetic; both operands are
    // below 8, so bit 3 of the raw difference flags a negative result.
    function automatic logic [3:0] torus_offset(input logic [2:0] dst,
                                                input logic [2:0] own,
                                                input logic [3:0] dim);
        logic [3:0] d;
        d = 4'(dst) - 4'(own);
        if (d[3]) begin
            d = d + dim;
        end
        return d;
    endfunction

    assign w_type  = bus.in_data[FLIT_SIZE-1:FLIT_SIZE-2];
    assign w_dst_x = bus.in_data[FLIT_SIZE-3 -: 3];
    assign w_dst_y = bus.in_data[FLIT_SIZE-6 -: 3];
    assign w_dst_z = bus.in_data[FLIT_SIZE-9 -: 3];

    assign w_dx = torus_offset(w_dst_x, X, 4'(DIM_X));
    assign w_dy = torus_offset(w_dst_y, Y, 4'(DIM_Y));
    assign w_dz = torus_offset(w_dst_z, Z, 4'(DIM_Z));

    // Dimension-order route; an offset of exactly half the ring goes positive.
    always_comb begin
        w_route = P_LOCAL;
        if (w_dx != 4'd0) begin
            w_route = (w_dx <= 4'(DIM_X / 2)) ? P_XP : P_XM;
        end else if (w_dy != 4'd0) begin
            w_route = (w_dy <= 4'(DIM_Y / 2)) ? P_YP : P_YM;
        end else if (w_dz != 4'd0) begin
            w_route = (w_dz <= 4'(DIM_Z / 2)) ? P_ZP : P_ZM;
        end
    end

    // Pop when the output slot is free or being drained this cycle.
    assign w_deq = rst && !bus.in_empty && (!r_out_valid || bus.out_ready);

    // FSM state and locked port register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_lock_port <= P_LOCAL;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_port <= w_lock_nxt;
        end
    end

    // Next state, lock and protocol-error detection; only a pop moves the FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_port;
        w_err_inc   = 1'b0;
        if (w_deq) begin
            case (w_type)
                T_HEAD: begin
                    w_state_nxt = S_BUSY;
                    w_lock_nxt  = w_route;
                    w_err_inc   = (r_state == S_BUSY);
                end
                T_SINGLE: begin
                    w_state_nxt = S_IDLE;
                    w_lock_nxt  = w_route;
                    w_err_inc   = (r_state == S_BUSY);
                end
                T_TAIL: begin
                    w_state_nxt = S_IDLE;
                    w_err_inc   = (r_state == S_IDLE);
                end
                default: begin
                    w_err_inc   = (r_state == S_IDLE);
                end
            endcase
        end
    end

    // Output decode: whether the popped flit is forwarded, and on which port.
    always_comb begin
        w_fwd      = 1'b0;
        w_port_nxt = r_lock_port;
        w_tail_nxt = 1'b0;
        case (w_type)
            T_HEAD: begin
                w_fwd      = 1'b1;
                w_port_nxt = w_route;
            end
            T_SINGLE: begin
                w_fwd      = 1'b1;
                w_port_nxt = w_route;
                w_tail_nxt = 1'b1;
            end
            T_TAIL: begin
                w_fwd      = (r_state == S_BUSY);
                w_tail_nxt = 1'b1;
            end
            default: begin
                w_fwd      = (r_state == S_BUSY);
            end
        endcase
    end

    // One-entry output stage; a dropped flit still frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_port  <= P_LOCAL;
            r_out_tail  <= 1'b0;
        end else if (w_deq) begin
            r_out_valid <= w_fwd;
            if (w_fwd) begin
                r_out_data <= bus.in_data;
                r_out_port <= w_port_nxt;
                r_out_tail <= w_tail_nxt;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating protocol-error counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_count <= 8'd0;
        end else if (w_err_inc && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.in_dequeue = w_deq;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_port   = r_out_port;
    assign bus.out_tail   = r_out_tail;
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_route_compute_unit.sv
// Purpose: directed self-checking bench for route_compute_unit at node (1,2,0)
//          of a 4x4x4 torus. A bench-side queue model feeds the unit.
module tb_route_compute_unit;

    localparam int unsigned FS = 64;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    route_compute_unit_if #(.FLIT_SIZE(FS)) bus ();

    route_compute_unit #(
        .X(3'd1), .Y(3'd2), .Z(3'd0),
        .DIM_X(4), .DIM_Y(4), .DIM_Z(4),
        .FLIT_SIZE(FS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] z;
        logic [2:0] port;
    } vec_t;

    logic [FS-1:0] q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [2:0] x,
                                         input logic [2:0] y, input logic [2:0] z,
                                         input logic [15:0] id);
        return {t, x, y, z, 37'd0, id};
    endfunction

    task automatic chk(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy);
        bus.in_empty  = (q.size() == 0);
        bus.in_data   = (q.size() == 0) ? '0 : q[0];
        bus.out_ready = rdy;
    endtask

    // One clock: inputs applied, pop decision sampled mid-cycle, outputs
    // settle 1 ns after the rising edge.
    task automatic step(input logic rdy, output logic popped);
        drive(rdy);
        @(negedge clk);
        popped = bus.in_dequeue;
        @(posedge clk);
        #1;
        if (popped && q.size() > 0) q.delete(0);
        drive(rdy);
    endtask

    initial begin
        vec_t          tbl[5];
        logic          p;
        logic [FS-1:0] f;
        logic [FS-1:0] pkt[8];
        int            budget;

        tbl[0] = '{x: 3'd1, y: 3'd2, z: 3'd0, port: 3'd0};
        tbl[1] = '{x: 3'd3, y: 3'd2, z: 3'd0, port: 3'd1};
        tbl[2] = '{x: 3'd0, y: 3'd2, z: 3'd0, port: 3'd2};
        tbl[3] = '{x: 3'd1, y: 3'd3, z: 3'd0, port: 3'd3};
        tbl[4] = '{x: 3'd1, y: 3'd2, z: 3'd3, port: 3'd6};

        // Reset held with a non-empty queue.
        q.push_back(mk(T_SINGLE, 3'd1, 3'd2, 3'd0, 16'd1));
        drive(1'b1);
        #2;
        chk("rst_dequeue", 64'(bus.in_dequeue), 64'd0);
        chk("rst_valid",   64'(bus.out_valid),  64'd0);
        chk("rst_err",     64'(bus.err_count),  64'd0);
        chk("rst_data",    bus.out_data,        64'd0);
        chk("rst_port",    64'(bus.out_port),   64'd0);
        step(1'b1, p);
        chk("rst_hold_no_pop", 64'(p), 64'd0);
        rst = 1'b1;
        step(1'b1, p);
        chk("first_pop",   64'(p),              64'd1);
        chk("first_valid", 64'(bus.out_valid),  64'd1);
        chk("first_port",  64'(bus.out_port),   64'd0);

        // Single-flit routing table.
        for (int i = 0; i < 5; i++) begin
            f = mk(T_SINGLE, tbl[i].x, tbl[i].y, tbl[i].z, 16'(100 + i));
            q.push_back(f);
            step(1'b1, p);
            chk($sformatf("single%0d_pop", i),   64'(p),             64'd1);
            chk($sformatf("single%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("single%0d_port", i),  64'(bus.out_port),  64'(tbl[i].port));
            chk($sformatf("single%0d_tail", i),  64'(bus.out_tail),  64'd1);
            chk($sformatf("single%0d_data", i),  bus.out_data,       f);
        end
        step(1'b1, p);
        chk("single_drain_valid", 64'(bus.out_valid), 64'd0);

        // Wormhole packet back-to-back.
        for (int i = 0; i < 5; i++) begin
            pkt[i] = mk((i == 0) ? T_HEAD : (i == 4) ? T_TAIL : T_BODY,
                        3'd2, 3'd0, 3'd0, 16'(200 + i));
            q.push_back(pkt[i]);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, p);
            chk($sformatf("worm%0d_pop", i),   64'(p),             64'd1);
            chk($sformatf("worm%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("worm%0d_port", i),  64'(bus.out_port),  64'd1);
            chk($sformatf("worm%0d_tail", i),  64'(bus.out_tail),  64'(i == 4));
            chk($sformatf("worm%0d_data", i),  bus.out_data,       pkt[i]);
        end
        step(1'b1, p);
        chk("worm_drain_valid", 64'(bus.out_valid), 64'd0);
        q.push_back(mk(T_SINGLE, 3'd1, 3'd2, 3'd0, 16'd250));
        step(1'b1, p);
        chk("worm_idle_port", 64'(bus.out_port),  64'd0);
        chk("worm_idle_err",  64'(bus.err_count), 64'd0);
        step(1'b1, p);

        // Backpressure mid-packet.
        for (int i = 0; i < 8; i++) begin
            pkt[i] = mk((i == 0) ? T_HEAD : (i == 7) ? T_TAIL : T_BODY,
                        3'd2, 3'd0, 3'd0, 16'(300 + i));
            q.push_back(pkt[i]);
        end
        step(1'b1, p);
        chk("bp_head_data", bus.out_data, pkt[0]);
        step(1'b1, p);
        chk("bp_b1_data", bus.out_data, pkt[1]);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, p);
            chk($sformatf("bp_stall%0d_pop", i),   64'(p),             64'd0);
            chk($sformatf("bp_stall%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp_stall%0d_data", i),  bus.out_data,       pkt[1]);
            chk($sformatf("bp_stall%0d_port", i),  64'(bus.out_port),  64'd1);
        end
        for (int i = 2; i < 8; i++) begin
            step(1'b1, p);
            chk($sformatf("bp_resume%0d_pop", i),  64'(p),             64'd1);
            chk($sformatf("bp_resume%0d_data", i), bus.out_data,       pkt[i]);
            chk($sformatf("bp_resume%0d_tail", i), 64'(bus.out_tail),  64'(i == 7));
        end
        step(1'b1, p);
        chk("bp_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_queue_empty", 64'(q.size()),      64'd0);

        // Protocol errors.
        q.push_back(mk(T_BODY, 3'd2, 3'd0, 3'd0, 16'd400));
        step(1'b1, p);
        chk("err_body_pop",   64'(p),             64'd1);
        chk("err_body_valid", 64'(bus.out_valid), 64'd0);
        chk("err_body_cnt",   64'(bus.err_count), 64'd1);
        q.push_back(mk(T_HEAD, 3'd2, 3'd0, 3'd0, 16'd401));
        step(1'b1, p);
        chk("err_head1_port", 64'(bus.out_port),  64'd1);
        chk("err_head1_cnt",  64'(bus.err_count), 64'd1);
        q.push_back(mk(T_HEAD, 3'd1, 3'd3, 3'd0, 16'd402));
        step(1'b1, p);
        chk("err_relock_port",  64'(bus.out_port),  64'd3);
        chk("err_relock_valid", 64'(bus.out_valid), 64'd1);
        chk("err_relock_cnt",   64'(bus.err_count), 64'd2);
        q.push_back(mk(T_BODY, 3'd0, 3'd0, 3'd0, 16'd403));
        step(1'b1, p);
        chk("err_relock_body_port", 64'(bus.out_port),  64'd3);
        chk("err_relock_body_cnt",  64'(bus.err_count), 64'd2);
        q.push_back(mk(T_TAIL, 3'd0, 3'd0, 3'd0, 16'd404));
        step(1'b1, p);
        chk("err_relock_tail_port", 64'(bus.out_port), 64'd3);
        chk("err_relock_tail_tail", 64'(bus.out_tail), 64'd1);
        for (int i = 0; i < 300; i++) begin
            q.push_back(mk(T_BODY, 3'd0, 3'd0, 3'd0, 16'(1000 + i)));
        end
        budget = 400;
        while (q.size() > 0 && budget > 0) begin
            step(1'b1, p);
            budget--;
        end
        chk("err_drain_in_budget", 64'(q.size()),      64'd0);
        chk("err_saturate",        64'(bus.err_count), 64'd255);
        chk("err_stray_valid",     64'(bus.out_valid), 64'd0);

        // Asynchronous reset mid-packet.
        q.push_back(mk(T_HEAD, 3'd2, 3'd0, 3'd0, 16'd500));
        step(1'b1, p);
        chk("areset_head_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("areset_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_err",   64'(bus.err_count), 64'd0);
        chk("areset_data",  bus.out_data,       64'd0);
        chk("areset_port",  64'(bus.out_port),  64'd0);
        chk("areset_tail",  64'(bus.out_tail),  64'd0);
        q.push_back(mk(T_BODY, 3'd2, 3'd0, 3'd0, 16'd501));
        step(1'b1, p);
        chk("areset_no_pop", 64'(p), 64'd0);
        rst = 1'b1;
        step(1'b1, p);
        chk("areset_body_pop",   64'(p),             64'd1);
        chk("areset_body_valid", 64'(bus.out_valid), 64'd0);
        chk("areset_body_err",   64'(bus.err_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
